// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid buffer: occupancy states and
// a helper that maps a state to its word count.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Number of words held in a given state.
    function automatic logic [1:0] occupancy(input pipe_state_t s);
        logic [1:0] n;
        case (s)
            EMPTY:   n = 2'd0;
            ONE:     n = 2'd1;
            FULL:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/register.sv
// Enable register: loads d when en is high, clears to zero on async reset.
module register #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold value unless enabled; reset forces zero independent of clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer. "main" always drives out_data; "skid" catches the
// word accepted while main is still waiting for the consumer. Handshake
// outputs depend only on the state register, so no combinational path runs
// from in_valid/out_ready to in_ready/out_valid.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    pipe_state_t      state;
    pipe_state_t      state_nxt;
    logic             push;
    logic             pop;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Handshake and occupancy decoded purely from the state register.
    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        count     = occupancy(state);
    end

    // Next-state rules; flush overrides everything and leaves data untouched.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) state_nxt = ONE;
                ONE: begin
                    if (push && !pop)
                        state_nxt = FULL;
                    else if (pop && !push)
                        state_nxt = EMPTY;
                end
                FULL:    if (pop) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // main reloads from the input (empty, or pass-through in ONE) or from
    // skid when draining FULL; skid only catches a push that cannot pass.
    assign main_en = !flush && (((state == EMPTY) && push) ||
                                ((state == ONE) && push && pop) ||
                                ((state == FULL) && pop));
    assign skid_en = !flush && (state == ONE) && push && !pop;
    assign main_d  = (state == FULL) ? skid_q : in_data;

    register #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    register #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

    assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: directed scenarios plus random traffic,
// checked against a queue-based model of a 2-deep FIFO.
module tb_pipe_skid_buffer;

    localparam int unsigned WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       count;

    int unsigned ncmp = 0;
    int unsigned nerr = 0;

    // Model: queue of held words plus the last word shown on out_data.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] shown;

    always #5 clk = ~clk;

    pipe_skid_buffer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int unsigned n;
        n = mq.size();
        check({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(n != 0));
        check({tag, ".in_ready"},  WIDTH'(in_ready),  WIDTH'(n < 2));
        check({tag, ".count"},     WIDTH'(count),     WIDTH'(n));
        check({tag, ".out_data"},  out_data, (n != 0) ? mq[0] : shown);
    endtask

    task automatic model_reset();
        mq.delete();
        shown = '0;
    endtask

    // Called from posedge+1: drive, check before the edge, advance the model.
    task automatic cycle(input string tag, input logic iv, input logic [WIDTH-1:0] id,
                         input logic ordy, input logic fl);
        bit do_push;
        bit do_pop;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check_model(tag);
        do_push = iv && (mq.size() < 2);
        do_pop  = ordy && (mq.size() != 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(id);
        end
        if (mq.size() != 0) shown = mq[0];
        #1;
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset values visible before any clock edge.
        #1;
        check("rst.out_valid", WIDTH'(out_valid), '0);
        check("rst.in_ready",  WIDTH'(in_ready),  WIDTH'(1));
        check("rst.count",     WIDTH'(count),     '0);
        check("rst.out_data",  out_data,          '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single word with one-cycle latency, then pop.
        cycle("single.push", 1'b1, 64'hA5, 1'b0, 1'b0);
        check("single.data", out_data, 64'hA5);
        check("single.count", WIDTH'(count), WIDTH'(1));
        cycle("single.pop", 1'b0, '0, 1'b1, 1'b0);
        check("single.empty", WIDTH'(count), '0);

        // Backpressure fill and drain in order.
        cycle("bp.p1", 1'b1, 64'h11, 1'b0, 1'b0);
        cycle("bp.p2", 1'b1, 64'h22, 1'b0, 1'b0);
        check("bp.full.count", WIDTH'(count), WIDTH'(2));
        check("bp.full.in_ready", WIDTH'(in_ready), '0);
        check("bp.full.data", out_data, 64'h11);
        cycle("bp.d1", 1'b0, '0, 1'b1, 1'b0);
        check("bp.second", out_data, 64'h22);
        cycle("bp.d2", 1'b0, '0, 1'b1, 1'b0);
        check("bp.drained", WIDTH'(out_valid), '0);

        // Streaming: one word per cycle, occupancy stays at one.
        cycle("stream.0", 1'b1, 64'd1, 1'b1, 1'b0);
        for (int i = 2; i <= 16; i++) begin
            check("stream.data", out_data, WIDTH'(i - 1));
            check("stream.count", WIDTH'(count), WIDTH'(1));
            cycle("stream", 1'b1, WIDTH'(i), 1'b1, 1'b0);
        end
        check("stream.last", out_data, 64'd16);
        idle("stream.tail");
        cycle("stream.drain", 1'b0, '0, 1'b1, 1'b0);

        // Flush while FULL discards both words and the concurrent push.
        cycle("fl.p1", 1'b1, 64'h33, 1'b0, 1'b0);
        cycle("fl.p2", 1'b1, 64'h44, 1'b0, 1'b0);
        cycle("fl.flush", 1'b1, 64'h55, 1'b1, 1'b1);
        check("fl.count", WIDTH'(count), '0);
        check("fl.valid", WIDTH'(out_valid), '0);
        for (int i = 0; i < 3; i++) begin
            check("fl.no55", WIDTH'(out_data == 64'h55), '0);
            cycle("fl.after", 1'b0, '0, 1'b1, 1'b0);
        end

        // Asynchronous reset between edges while FULL.
        cycle("ar.p1", 1'b1, 64'h61, 1'b0, 1'b0);
        cycle("ar.p2", 1'b1, 64'h62, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("ar.out_valid", WIDTH'(out_valid), '0);
        check("ar.in_ready",  WIDTH'(in_ready),  WIDTH'(1));
        check("ar.count",     WIDTH'(count),     '0);
        check("ar.out_data",  out_data,          '0);
        #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cycle("ar.push77", 1'b1, 64'h77, 1'b0, 1'b0);
        check("ar.data77", out_data, 64'h77);
        check("ar.valid77", WIDTH'(out_valid), WIDTH'(1));
        cycle("ar.pop", 1'b0, '0, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            cycle("rnd",
                  ($urandom % 4) != 0,
                  {$urandom, $urandom},
                  ($urandom % 3) != 0,
                  ($urandom % 40) == 0);
        end
        idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
